// File: rtl/mips_pkg.sv
// Shared MIPS pipeline package: default widths, the zero-register index and word/index types.
package mips_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned CNT_W    = 32;
   localparam int unsigned REG_ZERO = 0;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/mips_regfile_wb_if.sv
// MEM/WB-to-register-file bus: write-back payload, ID read ports and forwarding/debug outputs.
interface mips_regfile_wb_if #(
   parameter int unsigned DATA_W = mips_pkg::DATA_W,
   parameter int unsigned ADDR_W = mips_pkg::ADDR_W
);
   logic              RegWrite_in;
   logic              Mem2Reg_in;
   logic [DATA_W-1:0] Mem_in;
   logic [DATA_W-1:0] ALU_in;
   logic [ADDR_W-1:0] WriteReg_in;
   logic [ADDR_W-1:0] ReadReg1_in;
   logic [ADDR_W-1:0] ReadReg2_in;
   logic [DATA_W-1:0] ReadData1_out;
   logic [DATA_W-1:0] ReadData2_out;
   logic [DATA_W-1:0] WriteData_out;
   logic              WriteEn_out;
   logic [31:0]       WriteCount_out;

   modport master (
      output RegWrite_in, Mem2Reg_in, Mem_in, ALU_in, WriteReg_in, ReadReg1_in, ReadReg2_in,
      input  ReadData1_out, ReadData2_out, WriteData_out, WriteEn_out, WriteCount_out
   );

   modport slave (
      input  RegWrite_in, Mem2Reg_in, Mem_in, ALU_in, WriteReg_in, ReadReg1_in, ReadReg2_in,
      output ReadData1_out, ReadData2_out, WriteData_out, WriteEn_out, WriteCount_out
   );
endinterface

// File: rtl/mips_wb_mux.sv
// Mem2Reg write-back select: load data when sel is set, ALU result otherwise.
module mips_wb_mux #(
   parameter int unsigned W = mips_pkg::DATA_W
) (
   input  logic         sel,
   input  logic [W-1:0] mem,
   input  logic [W-1:0] alu,
   output logic [W-1:0] wb_data_c
);

   assign wb_data_c = sel ? mem : alu;

endmodule

// File: rtl/mips_regfile_wb.sv
// Write-back stage register file with two async read ports and a committed-write counter.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module mips_regfile_wb
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = mips_pkg::DATA_W,
   parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   mips_regfile_wb_if.slave   bus
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DATA_W-1:0] wb_data;
   logic              write_en;
   logic [CNT_W-1:0]  write_count;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   mips_wb_mux #(.W(DATA_W)) u_wb_mux (
      .sel       (bus.Mem2Reg_in),
      .mem       (bus.Mem_in),
      .alu       (bus.ALU_in),
      .wb_data_c (wb_data)
   );

   // Writes to the zero register are suppressed entirely, including the counter.
   assign write_en = bus.RegWrite_in && (bus.WriteReg_in != ADDR_W'(REG_ZERO));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
         write_count <= '0;
      end else if (write_en) begin
         regs[bus.WriteReg_in] <= wb_data;
         write_count           <= write_count + CNT_W'(1);
      end
   end

   // Read ports: zero register and reset override any bypass.
   always_comb begin
      rd1 = regs[bus.ReadReg1_in];
      rd2 = regs[bus.ReadReg2_in];
`ifdef REGFILE_BYPASS_EN
      if (write_en && (bus.ReadReg1_in == bus.WriteReg_in)) rd1 = wb_data;
      if (write_en && (bus.ReadReg2_in == bus.WriteReg_in)) rd2 = wb_data;
`endif
      if (rst || (bus.ReadReg1_in == ADDR_W'(REG_ZERO))) rd1 = '0;
      if (rst || (bus.ReadReg2_in == ADDR_W'(REG_ZERO))) rd2 = '0;
   end

   assign bus.ReadData1_out  = rd1;
   assign bus.ReadData2_out  = rd2;
   assign bus.WriteData_out  = wb_data;
   assign bus.WriteEn_out    = write_en;
   assign bus.WriteCount_out = 32'(write_count);

endmodule

// File: doc/mips_regfile_wb.md
# mips_regfile_wb

Write-back consumer and register file for the five-stage MIPS pipeline. Sits downstream of the MEM/WB stage register. Selects the write-back value from the memory or ALU result, commits it into a 32-entry general-purpose register file, and serves two asynchronous read ports to the ID stage. Also exports the write-back value for EX-stage forwarding and keeps a committed-write counter for debug.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width; depth = 2**ADDR_W

Ports (name direction width meaning):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- RegWrite_in  in  1  write enable from MEM/WB
- Mem2Reg_in  in  1  1 selects Mem_in, 0 selects ALU_in
- Mem_in  in  DATA_W  load data from MEM/WB
- ALU_in  in  DATA_W  ALU result from MEM/WB
- WriteReg_in  in  ADDR_W  destination register index
- ReadReg1_in  in  ADDR_W  read port 1 index (rs)
- ReadReg2_in  in  ADDR_W  read port 2 index (rt)
- ReadData1_out  out  DATA_W  read port 1 data, combinational
- ReadData2_out  out  DATA_W  read port 2 data, combinational
- WriteData_out  out  DATA_W  selected write-back value, combinational, for forwarding
- WriteEn_out  out  1  effective write this cycle: RegWrite_in and WriteReg_in != 0
- WriteCount_out  out  32  registered count of committed writes

## Operation
- WriteData_out = Mem2Reg_in ? Mem_in : ALU_in, every cycle, independent of RegWrite_in.
- Commit: on rising clk with rst=0 and WriteEn_out=1, regs[WriteReg_in] <= WriteData_out.
- Register 0 is hardwired to zero. Writes to index 0 are dropped, are not counted, and do not assert WriteEn_out. Reads of index 0 always return 0.
- Reads: ReadDataN_out = regs[ReadRegN_in], subject to zero and bypass rules.
- Reset: on rising clk with rst=1:
  - all regs cleared to 0
  - WriteCount_out cleared to 0
  - any concurrent write is discarded
- While rst=1, ReadData1_out and ReadData2_out are forced to 0.
- Counter: WriteCount_out increments by 1 per committed write. It wraps from 0xFFFFFFFF to 0.

## Timing
- Write latency: a value presented in cycle N is stored at the end of cycle N and is visible from storage in cycle N+1.
- Read latency: zero cycles (combinational from indices).
- Both read ports may address the same register or the write register in the same cycle. No conflict stalls; the block never back-pressures.
- Reset values of outputs:
  - ReadData1_out = 0, ReadData2_out = 0
  - WriteCount_out = 0
  - WriteData_out and WriteEn_out follow their inputs
- Reset mid-operation: an in-flight write in the reset cycle is lost. The first write after rst deasserts commits normally.

## Configuration
- REGFILE_BYPASS_EN defined: if WriteEn_out=1 and ReadRegN_in == WriteReg_in, ReadDataN_out = WriteData_out in the same cycle (write-before-read). This removes the WB→ID hazard.
- Not defined: the read returns the pre-write storage value. The hazard unit must stall one cycle for a WB→ID dependency.
- The zero-register rule overrides the bypass in both builds.

## Structure
- Shared package mips_pkg holds:
  - DATA_W and ADDR_W defaults
  - REG_ZERO index constant (0)
  - the reg_idx_t and word_t typedefs
- One sub-module, mips_wb_mux: the Mem2Reg 2:1 select, reused by the forwarding unit.
- Storage, bypass logic and counter stay in the top module.

## Test plan
- Reset: preload regs 1..31 with nonzero values, assert rst for one cycle → all reads return 0 and WriteCount_out=0 in the following cycle.
- Write/read: RegWrite=1, Mem2Reg=0, ALU_in=0x12345678, WriteReg=5; next cycle ReadReg1=5 → 0x12345678 and WriteCount_out=1. Repeat with Mem2Reg=1, Mem_in=0xDEADBEEF → 0xDEADBEEF.
- Zero register: write 0xFFFFFFFF to index 0 → WriteEn_out=0, reads of index 0 return 0, WriteCount_out unchanged.
- Same-cycle read of the write target: write 0xA5A5A5A5 to r7 (old value 0x1) with ReadReg1=ReadReg2=7 → both 0xA5A5A5A5 with REGFILE_BYPASS_EN, both 0x1 without; the next cycle returns 0xA5A5A5A5 in both builds.
- Reset collides with a write: rst=1 and a write of 0x55 to r3 in the same cycle → r3 reads 0 afterwards and WriteCount_out=0.
- Counter wrap: force WriteCount_out to 0xFFFFFFFF, then perform one write to r1 → WriteCount_out=0.
